// File: rtl/serial_alu_pkg.sv
// Shared types for the digit-serial ALU: op encodings, FSM states and op-class helpers.
package serial_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_SLT  = 3'd3,
        OP_AND  = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_OR   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // SLT is evaluated as a subtraction, so it shares the inverted-b / carry-in-1 path.
    function automatic logic op_is_sub(input op_e op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

    function automatic logic op_is_arith(input op_e op);
        return op_is_sub(op) || (op == OP_ADD);
    endfunction

endpackage

// File: rtl/serial_alu_digit.sv
// Combinational DIGIT-wide ALU slice: ripple adder plus bitwise logic ops.
module serial_alu_digit
    import serial_alu_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  op_e              i_op,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_res,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [DIGIT-1:0] w_b_eff;
    logic [DIGIT-1:0] w_sum;
    logic [DIGIT:0]   w_c;

    assign w_b_eff = op_is_sub(i_op) ? ~i_b : i_b;
    assign w_c[0]  = i_cin;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
            assign w_sum[gi]  = i_a[gi] ^ w_b_eff[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (i_a[gi] & w_b_eff[gi]) | (w_c[gi] & (i_a[gi] ^ w_b_eff[gi]));
        end
    endgenerate

    // Carry into the top bit of this digit; only meaningful on the last digit (overflow).
    assign o_cmsb = w_c[DIGIT-1];
    assign o_cout = w_c[DIGIT];

    always_comb begin
        o_res = w_sum;
        case (i_op)
            OP_XOR:  o_res = i_a ^ i_b;
            OP_AND:  o_res = i_a & i_b;
            OP_NAND: o_res = ~(i_a & i_b);
            OP_NOR:  o_res = ~(i_a | i_b);
            OP_OR:   o_res = i_a | i_b;
            default: o_res = w_sum;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Digit-serial ALU: DIGIT bits per cycle, LSB first, valid/ready on both sides.
// Define SERIAL_ALU_FLAGS_EN to build the overflow and zero flags; otherwise they read 0.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    op_e              r_op;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_carryout;
`ifdef SERIAL_ALU_FLAGS_EN
    logic             r_overflow;
    logic             r_zero;
`endif

    logic [DIGIT-1:0] w_res_d;
    logic             w_cout;
    logic             w_cmsb;
    logic             w_ovf;
    logic             w_slt;
    logic             w_arith;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_final;

    serial_alu_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .i_a    (r_a[DIGIT-1:0]),
        .i_b    (r_b[DIGIT-1:0]),
        .i_op   (r_op),
        .i_cin  (r_carry),
        .o_res  (w_res_d),
        .o_cout (w_cout),
        .o_cmsb (w_cmsb)
    );

    // Operands shift down one digit per cycle; result digits enter at the top.
    generate
        if (N == 1) begin : g_single
            assign w_a_next   = r_a;
            assign w_b_next   = r_b;
            assign w_res_next = w_res_d;
        end else begin : g_multi
            assign w_a_next   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
            assign w_b_next   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
            assign w_res_next = {w_res_d, r_result[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Overflow is always needed internally: SLT's answer is sign XOR overflow.
    assign w_ovf   = w_cmsb ^ w_cout;
    assign w_slt   = w_res_d[DIGIT-1] ^ w_ovf;
    assign w_arith = op_is_arith(r_op);
    assign w_final = (r_op == OP_SLT) ? WIDTH'(w_slt) : w_res_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_op        <= OP_ADD;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_carryout  <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_op       <= op_e'(op);
                        r_carry    <= op_is_sub(op_e'(op));
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= w_a_next;
                    r_b     <= w_b_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_result    <= w_final;
                        r_carryout  <= w_arith & w_cout;
`ifdef SERIAL_ALU_FLAGS_EN
                        r_overflow  <= w_arith & w_ovf;
                        r_zero      <= (w_final == '0);
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_result <= w_res_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carryout  = r_carryout;
`ifdef SERIAL_ALU_FLAGS_EN
    assign overflow  = r_overflow;
    assign zero      = r_zero;
`else
    assign overflow  = 1'b0;
    assign zero      = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: arithmetic reference model, per-cycle compare, directed pins.
`timescale 1ns/1ps
module tb_serial_alu;

    localparam int W = 32;
    localparam int D = 4;
    localparam int N = W / D;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carryout;
    logic         overflow;
    logic         zero;

    int n_tests = 0;
    int n_fail  = 0;

    serial_alu #(
        .WIDTH (W),
        .DIGIT (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain wide arithmetic; SLT uses a direct signed comparison.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o);
        exp_t       e;
        logic [W:0] s;
        e = '0;
        s = '0;
        case (o)
            3'd0: begin
                s   = {1'b0, x} + {1'b0, y};
                e.r = s[W-1:0];
                e.c = s[W];
                e.v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
            end
            3'd1, 3'd3: begin
                s   = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
                e.c = s[W];
                e.v = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
                e.r = (o == 3'd1) ? s[W-1:0] : W'($signed(x) < $signed(y));
            end
            3'd2:    e.r = x ^ y;
            3'd4:    e.r = x & y;
            3'd5:    e.r = ~(x & y);
            3'd6:    e.r = ~(x | y);
            default: e.r = x | y;
        endcase
        e.z = (e.r == '0);
`ifndef SERIAL_ALU_FLAGS_EN
        e.v = 1'b0;
        e.z = 1'b0;
`endif
        return e;
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model of the handshake: one op in flight, result N cycles after accept.
    int   cyc       = 0;
    int   acc_cyc   = 0;
    logic in_flight = 1'b0;
    exp_t exp_cur   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= 1'b0;
            cyc       <= 0;
        end else begin
            cyc <= cyc + 1;
            if (in_flight) begin
                if ((cyc - acc_cyc >= N) && out_ready) begin
                    in_flight <= 1'b0;
                    $display("[TB] out  r=0x%08h c=%b v=%b z=%b", exp_cur.r, exp_cur.c, exp_cur.v, exp_cur.z);
                end
            end else if (in_valid) begin
                in_flight <= 1'b1;
                acc_cyc   <= cyc + 1;
                exp_cur   <= model(a, b, op);
                $display("[TB] acc  op=%0d a=0x%08h b=0x%08h", op, a, b);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check1("in_ready", in_ready, !in_flight);
            check1("out_valid", out_valid, in_flight && (cyc - acc_cyc >= N));
            if (in_flight && (cyc - acc_cyc >= N)) begin
                check("result", result, exp_cur.r);
                check1("carryout", carryout, exp_cur.c);
                check1("overflow", overflow, exp_cur.v);
                check1("zero", zero, exp_cur.z);
            end
        end else begin
            check1("rst_in_ready", in_ready, 1'b1);
            check1("rst_out_valid", out_valid, 1'b0);
            check("rst_result", result, '0);
        end
    end

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o,
                         input int stall, input bit junk);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_in_ready: got 0 expected 1 within 50 cycles");
        end
        a         = x;
        b         = y;
        op        = o;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 50) begin
            a = $urandom;
            b = $urandom;
            if (junk) begin
                in_valid = 1'($urandom_range(0, 1));
                op       = 3'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", W'(lat), W'(N));
        repeat (stall) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check1("idle_after_release", in_ready, 1'b1);
    endtask

    // Pins the model to hand-computed values, then runs the same op through the DUT.
    task automatic pin(input string nm, input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o,
                       input logic [W-1:0] er, input logic ec, input logic ev, input logic ez, input int stall);
        exp_t m;
        m = model(x, y, o);
        check({nm, "_model_r"}, m.r, er);
        check1({nm, "_model_c"}, m.c, ec);
`ifdef SERIAL_ALU_FLAGS_EN
        check1({nm, "_model_v"}, m.v, ev);
        check1({nm, "_model_z"}, m.z, ez);
`endif
        do_op(x, y, o, stall, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check1("reset_in_ready", in_ready, 1'b1);
        check1("reset_out_valid", out_valid, 1'b0);

        pin("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 0);
        pin("sub_ovf",   32'h8000_0000, 32'h0000_0001, 3'd1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 5);
        pin("slt_m2_3",  32'hFFFF_FFFE, 32'h0000_0003, 3'd3, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 0);
        pin("slt_3_m2",  32'h0000_0003, 32'hFFFF_FFFE, 3'd3, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1);
        pin("slt_minmx", 32'h8000_0000, 32'h7FFF_FFFF, 3'd3, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 0);
        pin("xor",  32'hF0F0_F0F0, 32'hFF00_FF00, 3'd2, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0, 0);
        pin("and",  32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 2);
        pin("nand", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd5, 32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0, 0);
        pin("nor",  32'hF0F0_F0F0, 32'hFF00_FF00, 3'd6, 32'h000F_000F, 1'b0, 1'b0, 1'b0, 0);
        pin("or",   32'hF0F0_F0F0, 32'hFF00_FF00, 3'd7, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 0);

        // Abort an ADD at digit 4 with an asynchronous reset.
        a        = 32'h1234_5678;
        b        = 32'h1111_1111;
        op       = 3'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check1("abort_in_ready", in_ready, 1'b1);
        check1("abort_out_valid", out_valid, 1'b0);
        check("abort_result", result, '0);
        check1("abort_carryout", carryout, 1'b0);
        check1("abort_overflow", overflow, 1'b0);
        check1("abort_zero", zero, 1'b0);
        @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pin("add_2_3", 32'd2, 32'd3, 3'd0, 32'd5, 1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = $urandom;
            y = (i % 5 == 0) ? x : $urandom;
            if (i % 7 == 0) x = 32'h8000_0000;
            do_op(x, y, 3'($urandom), $urandom_range(0, 3), 1'b1);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
